// File: rtl/k580vt57_sched_if.sv
// k580vt57_sched bus bundle: CPU register port, DMA request/acknowledge pairs,
// the hold handshake and the memory cycle outputs.
interface k580vt57_sched_if;
  logic [3:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n;
  logic        ird_n;
  logic [3:0]  drq;
  logic [3:0]  dack;
  logic        hrq;
  logic        hlda;
  logic [15:0] addr;
  logic        aen;
  logic        memr_n;
  logic        memw_n;
  logic        tc;

  modport master (
    input  iaddr, idata, iwe_n, ird_n, drq, hlda,
    output odata, dack, hrq, addr, aen, memr_n, memw_n, tc
  );

  modport slave (
    output iaddr, idata, iwe_n, ird_n, drq, hlda,
    input  odata, dack, hrq, addr, aen, memr_n, memw_n, tc
  );
endinterface

// File: rtl/k580vt57_sched.sv
// Four-channel 8257-style DMA scheduler: hold handshake, fixed/rotating
// priority and a 4-state memory cycle per grant.
module k580vt57_sched (
  input  logic clk,
  input  logic reset_n,
  k580vt57_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, HOLD, S1, S2, S3, S4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q [4];
  logic [15:0] addr_d [4];
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];
  logic [3:0]  en_q, en_d;
  logic        rot_q, rot_d;
  logic        tcs_q, tcs_d;
  logic        auto_q, auto_d;
  logic        ff_q, ff_d;
  logic [3:0]  tcf_q, tcf_d;
  logic [1:0]  prio_q, prio_d;
  logic [1:0]  g_q, g_d;
  logic        upd_q, upd_d;
  logic        we_q, rd_q;

  logic        we_edge, rd_edge;
  logic        chreg, isc, is_stat;
  logic [1:0]  ch;
  logic [3:0]  pend;
  logic [1:0]  pick, base, idx;
  logic        found;
  logic        act, last;
  logic [1:0]  typ;
  logic [15:0] sel;

  assign we_edge = bus.iwe_n & ~we_q;
  assign rd_edge = bus.ird_n & ~rd_q;
  assign chreg   = ~bus.iaddr[3];
  assign isc     = bus.iaddr[0];
  assign ch      = bus.iaddr[2:1];
  assign is_stat = (bus.iaddr == 4'd8);
  assign pend    = bus.drq & en_q;

  // Scan from the rotating pointer, or from ch0 in fixed mode.
  always_comb begin
    pick  = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    base  = rot_q ? prio_q : 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && pend[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    unique case (state_q)
      IDLE: if (|pend) state_d = HOLD;
      HOLD: begin
        if (!(|pend)) begin
          state_d = IDLE;
        end else if (bus.hlda) begin
          state_d = S1;
          g_d     = pick;
        end
      end
      S1: state_d = S2;
      S2: state_d = S3;
      S3: state_d = S4;
      S4: begin
        if (bus.hlda && (|pend)) begin
          state_d = S1;
          g_d     = pick;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign act  = (state_q == S1) || (state_q == S2) || (state_q == S3);
  assign typ  = cnt_q[g_q][15:14];
  assign last = (cnt_q[g_q][13:0] == 14'd0);

  assign bus.hrq    = (state_q != IDLE);
  assign bus.aen    = act;
  assign bus.dack   = act ? (4'b0001 << g_q) : 4'b0000;
  assign bus.addr   = act ? addr_q[g_q] : 16'h0000;
  assign bus.tc     = act && last;
  assign bus.memr_n = !((state_q == S2) && (typ == 2'b10));
  assign bus.memw_n = !((state_q == S2) && (typ == 2'b01));

  always_comb begin
    bus.odata = 8'h00;
    sel       = isc ? cnt_q[ch] : addr_q[ch];
    if (chreg) begin
      bus.odata = ff_q ? sel[15:8] : sel[7:0];
    end else if (is_stat) begin
      bus.odata = {3'b000, upd_q, tcf_q};
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addr_d[i] = addr_q[i];
      cnt_d[i]  = cnt_q[i];
    end
    en_d   = en_q;
    rot_d  = rot_q;
    tcs_d  = tcs_q;
    auto_d = auto_q;
    ff_d   = ff_q;
    tcf_d  = tcf_q;
    prio_d = prio_q;
    upd_d  = 1'b0;

    if (rd_edge && is_stat) tcf_d = 4'h0;
    if (rd_edge && chreg) ff_d = ~ff_q;

    if (state_q == S3) begin
      prio_d = g_q + 2'd1;
      if (auto_q && (g_q == 2'd2) && last) begin
        addr_d[2] = addr_q[3];
        cnt_d[2]  = cnt_q[3];
        tcf_d[2]  = 1'b1;
        upd_d     = 1'b1;
      end else begin
        addr_d[g_q] = addr_q[g_q] + 16'd1;
        cnt_d[g_q]  = {typ, cnt_q[g_q][13:0] - 14'd1};
        if (last) begin
          tcf_d[g_q] = 1'b1;
          if (tcs_q) en_d[g_q] = 1'b0;
        end
      end
    end

    // A CPU write lands after the cycle update so it takes precedence.
    if (we_edge) begin
      if (chreg) begin
        if (isc) begin
          cnt_d[ch] = ff_q ? {bus.idata, cnt_q[ch][7:0]}
                           : {cnt_q[ch][15:8], bus.idata};
        end else begin
          addr_d[ch] = ff_q ? {bus.idata, addr_q[ch][7:0]}
                            : {addr_q[ch][15:8], bus.idata};
        end
        if (auto_q && ff_q && (ch == 2'd2)) begin
          if (isc) cnt_d[3] = {bus.idata, cnt_q[2][7:0]};
          else     addr_d[3] = {bus.idata, addr_q[2][7:0]};
        end
        ff_d = ~ff_q;
      end else if (is_stat) begin
        en_d   = bus.idata[3:0];
        rot_d  = bus.idata[4];
        tcs_d  = bus.idata[6];
        auto_d = bus.idata[7];
        ff_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      en_q   <= '0;
      rot_q  <= 1'b0;
      tcs_q  <= 1'b0;
      auto_q <= 1'b0;
      ff_q   <= 1'b0;
      tcf_q  <= '0;
      prio_q <= '0;
      g_q    <= '0;
      upd_q  <= 1'b0;
      we_q   <= 1'b1;
      rd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 4; i++) begin
        addr_q[i] <= addr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      en_q   <= en_d;
      rot_q  <= rot_d;
      tcs_q  <= tcs_d;
      auto_q <= auto_d;
      ff_q   <= ff_d;
      tcf_q  <= tcf_d;
      prio_q <= prio_d;
      g_q    <= g_d;
      upd_q  <= upd_d;
      we_q   <= bus.iwe_n;
      rd_q   <= bus.ird_n;
    end
  end

endmodule

// File: tb/tb_k580vt57_sched.sv
// Directed bench for k580vt57_sched: register-port vector table plus
// hand-written DMA burst, priority, TC-stop, autoload and abort sequences.
module tb_k580vt57_sched;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  k580vt57_sched_if bus();

  k580vt57_sched dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  logic auto_hl = 1'b0;
  logic hlda_man = 1'b0;
  logic hlda_d = 1'b0;
  always @(negedge clk) hlda_d = bus.hrq;
  assign bus.hlda = auto_hl ? hlda_d : hlda_man;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rd;
    logic [3:0] a;
    logic [7:0] d;
  } vec_t;

  vec_t vt [19];
  logic [3:0]  gr [8];
  logic [15:0] ga [8];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.iaddr = a;
    bus.idata = d;
    bus.iwe_n = 1'b0;
    @(negedge clk);
    bus.iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.iaddr = a;
    bus.ird_n = 1'b0;
    #1 d = bus.odata;
    @(negedge clk);
    bus.ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic collect(input int n, output int got);
    logic [3:0] prev;
    prev = bus.dack;
    got = 0;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (bus.dack != 4'h0 && prev == 4'h0) begin
        gr[got] = bus.dack;
        ga[got] = bus.addr;
        got++;
      end
      prev = bus.dack;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!bus.hrq) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, ok, 1'b1);
  endtask

  task automatic wait_hrq(input string nm);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.hrq) begin
        ok = 1'b1;
        break;
      end
    end
    check(nm, ok, 1'b1);
  endtask

  function automatic logic [24:0] outs();
    return {bus.hrq, bus.dack, bus.aen, bus.memr_n,
            bus.memw_n, bus.tc, bus.addr};
  endfunction

  localparam logic [24:0] RST_OUTS = {1'b0, 4'h0, 1'b0, 1'b1,
                                      1'b1, 1'b0, 16'h0000};

  initial begin
    logic [7:0] d, d2;
    int got, pulses, aerr, tcn, tcidx, wn, rn, upd;
    bit done, started;
    logic [3:0] prev;

    bus.iaddr = 4'h0;
    bus.idata = 8'h00;
    bus.iwe_n = 1'b1;
    bus.ird_n = 1'b1;
    bus.drq   = 4'h0;

    vt[0]  = '{1'b1, 4'd8, 8'h00};
    vt[1]  = '{1'b1, 4'd0, 8'h00};
    vt[2]  = '{1'b1, 4'd0, 8'h00};
    vt[3]  = '{1'b0, 4'd0, 8'h34};
    vt[4]  = '{1'b0, 4'd0, 8'h12};
    vt[5]  = '{1'b1, 4'd0, 8'h34};
    vt[6]  = '{1'b1, 4'd0, 8'h12};
    vt[7]  = '{1'b0, 4'd1, 8'h9F};
    vt[8]  = '{1'b0, 4'd8, 8'h00};
    vt[9]  = '{1'b0, 4'd1, 8'h55};
    vt[10] = '{1'b0, 4'd1, 8'h81};
    vt[11] = '{1'b1, 4'd1, 8'h55};
    vt[12] = '{1'b1, 4'd1, 8'h81};
    vt[13] = '{1'b0, 4'd2, 8'hCD};
    vt[14] = '{1'b0, 4'd2, 8'hAB};
    vt[15] = '{1'b1, 4'd3, 8'h00};
    vt[16] = '{1'b1, 4'd2, 8'hAB};
    vt[17] = '{1'b1, 4'd9, 8'h00};
    vt[18] = '{1'b1, 4'd0, 8'h34};

    repeat (3) @(negedge clk);
    check("reset_outs", outs(), RST_OUTS);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_outs", outs(), RST_OUTS);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].rd) begin
        cpu_rd(vt[i].a, d);
        check($sformatf("vec%0d", i), d, vt[i].d);
      end else begin
        cpu_wr(vt[i].a, vt[i].d);
      end
    end

    // Long read-type block on ch2
    auto_hl = 1'b1;
    cpu_wr(8, 8'h00);
    cpu_wr(4, 8'hD0);
    cpu_wr(4, 8'h76);
    cpu_wr(5, 8'h9F);
    cpu_wr(5, 8'h8F);
    cpu_wr(8, 8'h04);
    bus.drq = 4'b0100;
    check("hrq_pre", bus.hrq, 1'b0);
    @(negedge clk);
    check("hrq_rise", bus.hrq, 1'b1);
    pulses = 0; aerr = 0; tcn = 0; tcidx = -1; done = 1'b0;
    for (int c = 0; c < 17000; c++) begin
      @(negedge clk);
      if (!bus.memr_n) begin
        if (bus.addr !== 16'(16'h76D0 + pulses)) aerr++;
        if (bus.tc) begin
          tcn++;
          tcidx = pulses;
        end
        pulses++;
      end
      if (bus.tc) bus.drq = 4'b0000;
      if (!bus.hrq) begin
        done = 1'b1;
        break;
      end
    end
    check("blk_done", done, 1'b1);
    check("blk_pulses", pulses, 4000);
    check("blk_addr_err", aerr, 0);
    check("blk_tc_cnt", tcn, 1);
    check("blk_tc_last", tcidx, 3999);
    cpu_rd(8, d);
    check("blk_status", d, 8'h04);
    cpu_rd(4, d);
    cpu_rd(4, d2);
    check("blk_addr_end", {d2, d}, 16'h8670);
    cpu_rd(5, d);
    cpu_rd(5, d2);
    check("blk_cnt_end", {d2, d}, 16'hBFFF);

    // Fixed then rotating priority with ch0 and ch2 requesting
    cpu_wr(8, 8'h05);
    bus.drq = 4'b0101;
    collect(4, got);
    check("fix_got", got, 4);
    check("fix_grants", {gr[0], gr[1], gr[2], gr[3]}, 16'h1111);
    bus.drq = 4'b0100;
    collect(2, got);
    check("fix_ch2", {gr[0], gr[1]}, 8'h44);
    bus.drq = 4'b0000;
    wait_idle("fix_idle");
    cpu_wr(8, 8'h15);
    bus.drq = 4'b0101;
    collect(4, got);
    check("rot_got", got, 4);
    check("rot_grants", {gr[0], gr[1], gr[2], gr[3]}, 16'h1414);
    bus.drq = 4'b0000;
    wait_idle("rot_idle");

    // TC-stop on a 3-byte write-type block
    cpu_wr(8, 8'h42);
    cpu_wr(3, 8'h02);
    cpu_wr(3, 8'h40);
    cpu_rd(8, d);
    bus.drq = 4'b0010;
    wn = 0; rn = 0; started = 1'b0; done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.memw_n) wn++;
      if (!bus.memr_n) rn++;
      if (bus.hrq) started = 1'b1;
      if (started && !bus.hrq) begin
        done = 1'b1;
        break;
      end
    end
    check("tcs_done", done, 1'b1);
    check("tcs_memw", wn, 3);
    check("tcs_memr", rn, 0);
    repeat (10) @(negedge clk);
    check("tcs_disabled", bus.hrq, 1'b0);
    cpu_rd(8, d);
    check("tcs_status1", d, 8'h02);
    cpu_rd(8, d);
    check("tcs_status2", d, 8'h00);
    bus.drq = 4'b0000;

    // Autoload on ch2 with TC-stop also set
    cpu_wr(8, 8'hC4);
    cpu_wr(4, 8'h00);
    cpu_wr(4, 8'h10);
    cpu_wr(5, 8'h01);
    cpu_wr(5, 8'h00);
    cpu_rd(8, d);
    @(negedge clk);
    bus.iaddr = 4'd8;
    bus.drq = 4'b0100;
    got = 0; upd = 0; tcn = 0; started = 1'b0; done = 1'b0;
    prev = 4'h0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.dack != 4'h0 && prev == 4'h0) begin
        ga[got] = bus.addr;
        if (bus.tc) tcn++;
        got++;
        if (got == 4) bus.drq = 4'b0000;
      end
      prev = bus.dack;
      if (bus.odata[4]) upd++;
      if (bus.hrq) started = 1'b1;
      if (started && !bus.hrq) begin
        done = 1'b1;
        break;
      end
    end
    check("al_done", done, 1'b1);
    check("al_got", got, 4);
    check("al_addrs", {ga[0], ga[1], ga[2], ga[3]},
          64'h1000_1001_1000_1001);
    check("al_tc", tcn, 2);
    check("al_upd", upd, 2);
    cpu_rd(8, d);
    check("al_status", d, 8'h04);

    // hlda dropped during S2
    auto_hl = 1'b0;
    hlda_man = 1'b0;
    cpu_wr(8, 8'h01);
    cpu_wr(0, 8'h00);
    cpu_wr(0, 8'h20);
    cpu_wr(1, 8'h05);
    cpu_wr(1, 8'h80);
    cpu_rd(8, d);
    bus.drq = 4'b0001;
    wait_hrq("ab_hrq");
    hlda_man = 1'b1;
    @(negedge clk);
    check("ab_s1", {bus.aen, bus.dack, bus.addr}, {1'b1, 4'h1, 16'h2000});
    @(negedge clk);
    check("ab_s2", bus.memr_n, 1'b0);
    hlda_man = 1'b0;
    @(negedge clk);
    check("ab_s3", {bus.memr_n, bus.dack}, {1'b1, 4'h1});
    @(negedge clk);
    check("ab_s4", {bus.hrq, bus.aen, bus.dack}, {1'b1, 1'b0, 4'h0});
    @(negedge clk);
    check("ab_idle", bus.hrq, 1'b0);
    bus.drq = 4'b0000;
    repeat (3) @(negedge clk);
    cpu_rd(0, d);
    cpu_rd(0, d2);
    check("ab_addr", {d2, d}, 16'h2001);
    cpu_rd(1, d);
    cpu_rd(1, d2);
    check("ab_cnt", {d2, d}, 16'h8004);

    // Asynchronous reset in the middle of S2
    bus.drq = 4'b0001;
    wait_hrq("rst_hrq");
    hlda_man = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_s2", bus.memr_n, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outs", outs(), RST_OUTS);
    bus.drq = 4'b0000;
    hlda_man = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cpu_rd(0, d);
    cpu_rd(0, d2);
    check("rst_addr", {d2, d}, 16'h0000);
    cpu_rd(8, d);
    check("rst_status", d, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
